// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types for the UART transmit controller: FSM states, config byte layout,
// reset configuration and the data-length decode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       two_stop;
        logic       par_odd;
        logic       par_en;
        logic [1:0] len_code;
    } uart_cfg_t;

    localparam logic [7:0] CFG_RESET = 8'h03;

    function automatic logic [3:0] data_len(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side bundle of the UART transmit controller. Optional brk line exists only
// when UART_TX_BREAK_EN is defined.
interface uart_tx_ctrl_if #(parameter int MAX_DATA_W = 8);
    logic                  confmode;
    logic [7:0]            cfg_din;
    logic                  send;
    logic [MAX_DATA_W-1:0] tx_data;
`ifdef UART_TX_BREAK_EN
    logic                  brk;
`endif
    logic                  tx;
    logic                  busy;
    logic                  done;
    logic [7:0]            cfg_out;
    logic [2:0]            state_out;

`ifdef UART_TX_BREAK_EN
    modport master (output confmode, cfg_din, send, tx_data, brk,
                    input  tx, busy, done, cfg_out, state_out);
    modport slave  (input  confmode, cfg_din, send, tx_data, brk,
                    output tx, busy, done, cfg_out, state_out);
`else
    modport master (output confmode, cfg_din, send, tx_data,
                    input  tx, busy, done, cfg_out, state_out);
    modport slave  (input  confmode, cfg_din, send, tx_data,
                    output tx, busy, done, cfg_out, state_out);
`endif
endinterface

// File: rtl/uart_tx_ctrl_edge_det.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 transition.
module uart_edge_det (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic rise
);
    logic prev;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= d;
            rise <= d & ~prev;
        end
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// Parametrised UART transmitter: runtime length/parity/stop config, internal baud
// divider, busy/done handshake. UART_TX_BREAK_EN adds a 16-bit-period break command.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DIV_W        = 16,
    parameter int MAX_DATA_W   = 8
) (
    input logic           Clk,
    input logic           Rst,
    uart_tx_ctrl_if.slave bus
);
    uart_state_e           state, nxt;
    logic [DIV_W-1:0]      cnt, cnt_n;
    logic [3:0]            idx, idx_n;
    logic [MAX_DATA_W-1:0] data_q, data_n;
    logic                  par_q, par_n;
    logic                  stop_last, last_n;
    uart_cfg_t             cfg_q, cfg_n;
    logic                  tx_q, tx_n, busy_q, busy_n, done_q, done_n;
    logic                  cfg_rise, send_rise;
    logic [3:0]            len;
    logic [MAX_DATA_W-1:0] mask;
    logic                  bit_end;

    uart_edge_det u_cfg_ed  (.Clk(Clk), .Rst(Rst), .d(bus.confmode), .rise(cfg_rise));
    uart_edge_det u_send_ed (.Clk(Clk), .Rst(Rst), .d(bus.send),     .rise(send_rise));
`ifdef UART_TX_BREAK_EN
    logic brk_rise;
    uart_edge_det u_brk_ed  (.Clk(Clk), .Rst(Rst), .d(bus.brk),      .rise(brk_rise));
`endif

    assign bit_end = (cnt == DIV_W'(CLKS_PER_BIT - 1));
    // cfg_n already reflects a config edge in this cycle, so a same-cycle send uses it
    assign len     = data_len(cfg_n.len_code);
    assign mask    = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - int'(len));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            stop_last <= 1'b0;
            cfg_q     <= uart_cfg_t'(CFG_RESET);
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_n;
            idx       <= idx_n;
            data_q    <= data_n;
            par_q     <= par_n;
            stop_last <= last_n;
            cfg_q     <= cfg_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        nxt    = state;
        cnt_n  = bit_end ? '0 : cnt + 1'b1;
        idx_n  = idx;
        data_n = data_q;
        par_n  = par_q;
        last_n = stop_last;
        cfg_n  = cfg_q;
        done_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (cfg_rise)
                    cfg_n = uart_cfg_t'({3'b000, bus.cfg_din[4:0]});
`ifdef UART_TX_BREAK_EN
                if (brk_rise) nxt = BREAK;
                else
`endif
                if (send_rise) begin
                    nxt    = START;
                    data_n = bus.tx_data;
                    par_n  = ^(bus.tx_data & mask) ^ cfg_n.par_odd;
                end
            end
            START:
                if (bit_end) nxt = DATA;
            DATA:
                if (bit_end) begin
                    data_n = data_q >> 1;
                    if (idx == len - 4'd1) begin
                        nxt    = cfg_q.par_en ? PARITY : STOP;
                        last_n = ~cfg_q.two_stop;
                        idx_n  = '0;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            PARITY:
                if (bit_end) nxt = STOP;
            STOP:
                if (bit_end) begin
                    if (stop_last) begin
                        nxt    = IDLE;
                        done_n = 1'b1;
                    end else begin
                        last_n = 1'b1;
                    end
                end
`ifdef UART_TX_BREAK_EN
            BREAK:
                if (bit_end) begin
                    if (idx == 4'd15) begin
                        nxt    = STOP;
                        last_n = 1'b1;
                        idx_n  = '0;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
`endif
            default: nxt = IDLE;
        endcase

        // Line level is computed from the next state so tx stays a plain register
        case (nxt)
            START, BREAK: tx_n = 1'b0;
            DATA:         tx_n = data_n[0];
            PARITY:       tx_n = par_n;
            default:      tx_n = 1'b1;
        endcase
        busy_n = (nxt != IDLE);
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_out   = cfg_q;
    assign bus.state_out = state;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a frame model pushes expected line waveforms,
// an independent monitor records tx while busy and compares on frame completion.
module tb_uart_tx_ctrl;
    localparam int CPB = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    uart_tx_ctrl_if #(.MAX_DATA_W(8)) bus();

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DIV_W(16), .MAX_DATA_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus)
    );

    typedef struct {
        logic [31:0] bits;
        int          n;
    } frame_t;

    frame_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mcfg = 8'h03;

    // Expected frame: start, len data bits LSB first, optional parity, 1 or 2 stops
    function automatic frame_t model(input logic [7:0] cfg, input logic [7:0] d);
        frame_t f;
        int len  = 5 + int'(cfg[1:0]);
        int ones = 0;
        f.bits = '0;
        f.n    = 0;
        f.bits[f.n] = 1'b0; f.n++;
        for (int i = 0; i < len; i++) begin
            f.bits[f.n] = d[i];
            ones += int'(d[i]);
            f.n++;
        end
        if (cfg[2]) begin
            f.bits[f.n] = ((ones % 2) == 1) ^ cfg[3];
            f.n++;
        end
        f.bits[f.n] = 1'b1; f.n++;
        if (cfg[4]) begin
            f.bits[f.n] = 1'b1; f.n++;
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: record tx each cycle the DUT is busy, compare when busy drops
    logic   rec[$];
    frame_t cur;
    bit     rec_on = 1'b0;

    always @(negedge Clk) begin
        if (Rst) begin
            rec_on = 1'b0;
            rec.delete();
        end else if (bus.busy) begin
            if (!rec_on) begin
                rec_on = 1'b1;
                rec.delete();
                chk("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                else begin cur.bits = '0; cur.n = 0; end
            end
            rec.push_back(bus.tx);
        end else if (rec_on) begin
            int mism = 0;
            rec_on = 1'b0;
            for (int i = 0; i < rec.size(); i++)
                if (i / CPB >= 32 || rec[i] !== cur.bits[i / CPB]) mism++;
            chk("frame_len", rec.size(), cur.n * CPB);
            chk("frame_bits_mismatches", mism, 0);
            chk("done_at_end", bus.done, 1);
        end else if (bus.done) begin
            chk("stray_done", bus.done, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_frame();
        int t = 0;
        while (!bus.busy && t < 20) begin cyc(1); t++; end
        while (bus.busy && t < 400) begin cyc(1); t++; end
        chk("frame_wait_bound", bus.busy, 0);
        cyc(2);
    endtask

    task automatic send_frame(input logic [7:0] d);
        bus.tx_data = d;
        exp_q.push_back(model(mcfg, d));
        bus.send = 1'b1;
        cyc(2);
        bus.send = 1'b0;
        wait_frame();
    endtask

    task automatic set_cfg(input logic [7:0] c);
        bus.cfg_din  = c;
        bus.confmode = 1'b1;
        cyc(2);
        bus.confmode = 1'b0;
        cyc(2);
        mcfg = {3'b000, c[4:0]};
        chk("cfg_out", bus.cfg_out, mcfg);
    endtask

    initial begin
        bus.confmode = 1'b0;
        bus.cfg_din  = 8'h00;
        bus.send     = 1'b0;
        bus.tx_data  = 8'h00;
`ifdef UART_TX_BREAK_EN
        bus.brk      = 1'b0;
`endif
        cyc(3);
        chk("rst_tx",      bus.tx,        1);
        chk("rst_busy",    bus.busy,      0);
        chk("rst_done",    bus.done,      0);
        chk("rst_cfg_out", bus.cfg_out,   8'h03);
        chk("rst_state",   bus.state_out, 0);
        Rst = 1'b0;
        cyc(2);

        // Send-edge latency: sampled at edge k, START visible after edge k+1
        bus.tx_data = 8'hA5;
        exp_q.push_back(model(mcfg, 8'hA5));
        bus.send = 1'b1;
        cyc(1);
        chk("edge_k_busy", bus.busy, 0);
        cyc(1);
        chk("edge_k1_state", bus.state_out, 1);
        chk("edge_k1_tx",    bus.tx,        0);
        chk("edge_k1_busy",  bus.busy,      1);
        bus.send = 1'b0;
        wait_frame();

        set_cfg(8'h07); send_frame(8'hA5);
        set_cfg(8'h0F); send_frame(8'hA5);
        set_cfg(8'h10); send_frame(8'hFF);
        set_cfg(8'h03);

        // Held send -> one frame only
        bus.tx_data = 8'h3C;
        exp_q.push_back(model(mcfg, 8'h3C));
        bus.send = 1'b1;
        cyc(200);
        bus.send = 1'b0;
        cyc(5);

        // Mid-frame send and config edges are dropped
        bus.tx_data = 8'h5A;
        exp_q.push_back(model(mcfg, 8'h5A));
        bus.send = 1'b1;
        cyc(2);
        bus.send = 1'b0;
        cyc(8);
        bus.send = 1'b1; bus.cfg_din = 8'h00; bus.confmode = 1'b1;
        cyc(2);
        bus.send = 1'b0; bus.confmode = 1'b0;
        wait_frame();
        chk("cfg_ignored_busy", bus.cfg_out, mcfg);

        // Config and send edges together: frame uses the new config
        bus.cfg_din = 8'h16;
        mcfg        = 8'h16;
        bus.tx_data = 8'hC9;
        exp_q.push_back(model(mcfg, 8'hC9));
        bus.confmode = 1'b1; bus.send = 1'b1;
        cyc(2);
        bus.confmode = 1'b0; bus.send = 1'b0;
        wait_frame();
        chk("cfg_same_cycle", bus.cfg_out, 8'h16);

        // Reset in the middle of DATA
        set_cfg(8'h07);
        bus.tx_data = 8'h81;
        exp_q.push_back(model(mcfg, 8'h81));
        bus.send = 1'b1;
        cyc(2);
        bus.send = 1'b0;
        for (int t = 0; t < 50 && bus.state_out != 3'd2; t++) cyc(1);
        chk("reach_data", bus.state_out, 2);
        cyc(9);
        Rst = 1'b1;
        cyc(1);
        chk("midrst_tx",      bus.tx,      1);
        chk("midrst_busy",    bus.busy,    0);
        chk("midrst_cfg_out", bus.cfg_out, 8'h03);
        Rst  = 1'b0;
        mcfg = 8'h03;
        cyc(2);
        send_frame(8'h6E);

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(1, 0) == 1) set_cfg(8'($urandom));
            send_frame(8'($urandom));
        end

`ifdef UART_TX_BREAK_EN
        begin
            frame_t bf;
            bf.bits = 32'h0001_0000;
            bf.n    = 17;
            exp_q.push_back(bf);
            bus.brk = 1'b1; bus.send = 1'b1;
            cyc(2);
            bus.brk = 1'b0; bus.send = 1'b0;
            wait_frame();
            cyc(5);
        end
`endif

        cyc(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
